line_buffer_feeder: RTL and testbench

//  Producer side of the 3x3 window-register interface. Accepts a raster pixel stream over valid/ready.

---
 rtl/conv2d_pkg.sv | 14 +
 rtl/line_ram.sv | 32 +++
 rtl/line_buffer_feeder.sv | 185 ++++++++++++++++++
 tb/tb_line_buffer_feeder.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/conv2d_pkg.sv
// Shared types and default dimensions for the Conv2d input-side blocks.
package conv2d_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int IMG_WIDTH_DEF  = 64;
  localparam int IMG_HEIGHT_DEF = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fsm_state_e;

endpackage

// File: rtl/line_ram.sv
// Single-clock line RAM: synchronous write, registered read, same-address read returns old data.
module line_ram #(
  parameter int DW    = 16,
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [DW-1:0] rd_data_o,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rd_data_q;

  // Storage is deliberately not reset; consumers mask stale rows.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)     rd_data_q <= '0;
    else if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/line_buffer_feeder.sv
// Raster stream to 3-row column feeder for the 3x3 window register, with a two-row line buffer.
// state | meaning
// IDLE  | waiting for a start with a legal frame size
// RUN   | accepting pixels, one column strobe per transfer
// DRAIN | two cycles flushing the strobe / win_valid pipeline
module line_buffer_feeder
  import conv2d_pkg::*;
#(
  parameter  int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter  int IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter  int IMG_HEIGHT = IMG_HEIGHT_DEF,
  localparam int CW         = $clog2(IMG_WIDTH + 1),
  localparam int RW         = $clog2(IMG_HEIGHT + 1),
  localparam int AW         = $clog2(IMG_WIDTH)
) (
  input  logic                  clk,
  input  logic                  Rst_linebuf,
  input  logic                  start,
  input  logic [CW-1:0]         cfg_width,
  input  logic [RW-1:0]         cfg_height,
  input  logic [DATA_WIDTH-1:0] in_pixel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_row_n,
  output logic [DATA_WIDTH-1:0] out_row_n_1,
  output logic [DATA_WIDTH-1:0] out_row_n_2,
  output logic                  Wr_window,
  output logic                  Shift_window,
  output logic                  win_valid,
  output logic                  busy,
  output logic                  done
);

  fsm_state_e      state_q, state_d;
  logic [CW-1:0]   width_q, width_d;
  logic [RW-1:0]   height_q, height_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic            drain_q, drain_d;

  logic            xfer;
  logic            col_last;
  logic            row_last;
  logic            cfg_ok;

  logic            s1_wr_q;
  logic [DATA_WIDTH-1:0] s1_pix_q;
  logic            s1_mask1_q;
  logic            s1_mask2_q;
  logic            s1_win_q;
  logic            s1_last_q;
  logic [AW-1:0]   s1_col_q;
  logic            win_valid_q;
  logic            done_q;

  logic [DATA_WIDTH-1:0] ram_a_rd;
  logic [DATA_WIDTH-1:0] ram_b_rd;

  assign xfer     = in_valid & in_ready;
  assign col_last = (col_q == width_q - CW'(1));
  assign row_last = (row_q == height_q - RW'(1));
  assign cfg_ok   = (cfg_width  >= CW'(3)) && (cfg_width  <= CW'(IMG_WIDTH)) &&
                    (cfg_height >= RW'(3)) && (cfg_height <= RW'(IMG_HEIGHT));

  always_ff @(posedge clk or negedge Rst_linebuf) begin
    if (!Rst_linebuf) begin
      state_q  <= IDLE;
      width_q  <= '0;
      height_q <= '0;
      col_q    <= '0;
      row_q    <= '0;
      drain_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      width_q  <= width_d;
      height_q <= height_d;
      col_q    <= col_d;
      row_q    <= row_d;
      drain_q  <= drain_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    width_d  = width_q;
    height_d = height_q;
    col_d    = col_q;
    row_d    = row_q;
    drain_d  = drain_q;
    unique case (state_q)
      IDLE: begin
        if (start && cfg_ok) begin
          state_d  = RUN;
          width_d  = cfg_width;
          height_d = cfg_height;
          col_d    = '0;
          row_d    = '0;
        end
      end
      RUN: begin
        if (xfer) begin
          if (col_last) begin
            col_d = '0;
            row_d = row_q + RW'(1);
            if (row_last) begin
              state_d = DRAIN;
              drain_d = 1'b1;
            end
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      DRAIN: begin
        if (drain_q == 1'b0) state_d = IDLE;
        else                 drain_d = drain_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == RUN);
    busy     = (state_q != IDLE);
  end

  // Stage 1 captures the column and its validity flags; stage 2 qualifies the window.
  always_ff @(posedge clk or negedge Rst_linebuf) begin
    if (!Rst_linebuf) begin
      s1_wr_q     <= 1'b0;
      s1_pix_q    <= '0;
      s1_mask1_q  <= 1'b0;
      s1_mask2_q  <= 1'b0;
      s1_win_q    <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_col_q    <= '0;
      win_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      s1_wr_q <= xfer;
      if (xfer) begin
        s1_pix_q   <= in_pixel;
        s1_mask1_q <= (row_q != RW'(0));
        s1_mask2_q <= (row_q >= RW'(2));
        s1_win_q   <= (row_q >= RW'(2)) && (col_q >= CW'(2));
        s1_last_q  <= col_last && row_last;
        s1_col_q   <= col_q[AW-1:0];
      end
      win_valid_q <= s1_wr_q & s1_win_q;
      done_q      <= s1_wr_q & s1_last_q;
    end
  end

  line_ram #(.DW(DATA_WIDTH), .DEPTH(IMG_WIDTH), .AW(AW)) u_ram_a (
    .clk_i     (clk),
    .rst_n_i   (Rst_linebuf),
    .rd_en_i   (xfer),
    .rd_addr_i (col_q[AW-1:0]),
    .rd_data_o (ram_a_rd),
    .wr_en_i   (xfer),
    .wr_addr_i (col_q[AW-1:0]),
    .wr_data_i (in_pixel)
  );

  // ramB takes ramA's old word one cycle late; the next transfer always hits another column.
  line_ram #(.DW(DATA_WIDTH), .DEPTH(IMG_WIDTH), .AW(AW)) u_ram_b (
    .clk_i     (clk),
    .rst_n_i   (Rst_linebuf),
    .rd_en_i   (xfer),
    .rd_addr_i (col_q[AW-1:0]),
    .rd_data_o (ram_b_rd),
    .wr_en_i   (s1_wr_q),
    .wr_addr_i (s1_col_q),
    .wr_data_i (ram_a_rd)
  );

  assign out_row_n    = s1_pix_q;
  assign out_row_n_1  = s1_mask1_q ? ram_a_rd : '0;
  assign out_row_n_2  = s1_mask2_q ? ram_b_rd : '0;
  assign Wr_window    = s1_wr_q;
  assign Shift_window = s1_wr_q;
  assign win_valid    = win_valid_q;
  assign done         = done_q;

endmodule

// File: tb/tb_line_buffer_feeder.sv
// Scoreboard bench for line_buffer_feeder: image-level reference model, decoupled monitor.
module tb_line_buffer_feeder;

  localparam int DW = 16;
  localparam int IW = 64;
  localparam int IH = 64;
  localparam int CW = $clog2(IW + 1);
  localparam int RW = $clog2(IH + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [CW-1:0] cfg_width;
  logic [RW-1:0] cfg_height;
  logic [DW-1:0] in_pixel;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_row_n, out_row_n_1, out_row_n_2;
  logic          Wr_window, Shift_window, win_valid, busy, done;

  always #5 clk = ~clk;

  line_buffer_feeder #(.DATA_WIDTH(DW), .IMG_WIDTH(IW), .IMG_HEIGHT(IH)) dut (
    .clk          (clk),
    .Rst_linebuf  (rst_n),
    .start        (start),
    .cfg_width    (cfg_width),
    .cfg_height   (cfg_height),
    .in_pixel     (in_pixel),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_row_n    (out_row_n),
    .out_row_n_1  (out_row_n_1),
    .out_row_n_2  (out_row_n_2),
    .Wr_window    (Wr_window),
    .Shift_window (Shift_window),
    .win_valid    (win_valid),
    .busy         (busy),
    .done         (done)
  );

  typedef struct {
    int            due;
    logic [DW-1:0] n;
    logic [DW-1:0] n1;
    logic [DW-1:0] n2;
    bit            win;
    bit            fin;
  } exp_t;

  exp_t          q[$];
  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  bit            mon_en = 1'b0;
  bit            pend_win = 1'b0;
  bit            pend_done = 1'b0;
  int            win_cnt = 0;
  logic [DW-1:0] img [IH][IW];

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: a strobe is expected exactly one cycle after each modelled transfer.
  always @(negedge clk) begin
    bit   es;
    exp_t e;
    if (mon_en) begin
      chk("win_valid", {31'd0, win_valid}, {31'd0, pend_win});
      chk("done", {31'd0, done}, {31'd0, pend_done});
      if (win_valid) win_cnt++;
      es = (q.size() > 0) && (q[0].due == cyc);
      chk("wr_window", {31'd0, Wr_window}, {31'd0, es});
      chk("shift_window", {31'd0, Shift_window}, {31'd0, es});
      if (es) begin
        e = q.pop_front();
        chk("out_row_n", {16'd0, out_row_n}, {16'd0, e.n});
        chk("out_row_n_1", {16'd0, out_row_n_1}, {16'd0, e.n1});
        chk("out_row_n_2", {16'd0, out_row_n_2}, {16'd0, e.n2});
        pend_win  = e.win;
        pend_done = e.fin;
      end else begin
        pend_win  = 1'b0;
        pend_done = 1'b0;
      end
    end
  end

  task automatic fill(input int w, input int h, input int kind);
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++)
        case (kind)
          0:       img[r][c] = DW'(r * w + c);
          1:       img[r][c] = DW'($urandom);
          default: img[r][c] = 16'h7FFF;
        endcase
  endtask

  // Called at a negedge; returns at the negedge where the FSM is in RUN.
  task automatic start_frame(input int w, input int h);
    start      = 1'b1;
    cfg_width  = CW'(w);
    cfg_height = RW'(h);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
  endtask

  // mode 0: continuous, 1: 1010 stall pattern, 2: random stalls
  task automatic feed(input int w, input int h, input int mode, input int limit);
    int n = 0;
    int ph = 0;
    bit go;
    exp_t e;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        if (n >= limit) return;
        do begin
          go = (mode == 0) || (mode == 1 && ph == 0) ||
               (mode == 2 && $urandom_range(0, 1) == 1);
          ph = 1 - ph;
          if (!go) begin
            in_valid = 1'b0;
            @(negedge clk);
          end
        end while (!go);
        in_valid = 1'b1;
        in_pixel = img[r][c];
        e.due = cyc + 1;
        e.n   = img[r][c];
        e.n1  = (r >= 1) ? img[r-1][c] : '0;
        e.n2  = (r >= 2) ? img[r-2][c] : '0;
        e.win = (r >= 2) && (c >= 2);
        e.fin = (r == h - 1) && (c == w - 1);
        q.push_back(e);
        chk("in_ready_run", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        n++;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic finish_frame(input int w, input int h, input int win_before);
    int k = 0;
    while (!done && k < 8) begin
      @(negedge clk);
      k++;
    end
    chk("done_seen", {31'd0, done}, 32'd1);
    @(negedge clk);
    chk("busy_idle", {31'd0, busy}, 32'd0);
    chk("in_ready_idle", {31'd0, in_ready}, 32'd0);
    chk("win_count", win_cnt - win_before, (w - 2) * (h - 2));
  endtask

  task automatic run_frame(input int w, input int h, input int kind, input int mode);
    int wb;
    fill(w, h, kind);
    wb = win_cnt;
    start_frame(w, h);
    feed(w, h, mode, w * h);
    finish_frame(w, h, wb);
  endtask

  initial begin
    int w;
    int h;
    rst_n      = 1'b0;
    start      = 1'b0;
    cfg_width  = '0;
    cfg_height = '0;
    in_pixel   = '0;
    in_valid   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rows", {out_row_n, out_row_n_1} | {16'd0, out_row_n_2}, 32'd0);
    chk("rst_strobes", {28'd0, Wr_window, Shift_window, win_valid, done}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;

    // T1: reset in the middle of a frame with in_valid held high
    fill(8, 8, 1);
    start_frame(8, 8);
    feed(8, 8, 0, 20);
    in_valid = 1'b1;
    mon_en   = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("t1_in_ready", {31'd0, in_ready}, 32'd0);
    chk("t1_busy", {31'd0, busy}, 32'd0);
    chk("t1_rows", {out_row_n, out_row_n_1} | {16'd0, out_row_n_2}, 32'd0);
    chk("t1_strobes", {28'd0, Wr_window, Shift_window, win_valid, done}, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    q.delete();
    pend_win  = 1'b0;
    pend_done = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;

    // T2/T3: 4x4 ramp, continuous then 1010 stalls
    run_frame(4, 4, 0, 0);
    run_frame(4, 4, 0, 1);

    // Random frames with random stalls
    for (int i = 0; i < 3; i++) begin
      w = $urandom_range(3, 10);
      h = $urandom_range(3, 7);
      run_frame(w, h, 1, 2);
    end

    // T5: illegal sizes are ignored
    start      = 1'b1;
    cfg_width  = CW'(2);
    cfg_height = RW'(4);
    @(negedge clk);
    cfg_width  = CW'(IW + 1);
    cfg_height = RW'(5);
    @(negedge clk);
    cfg_width  = CW'(5);
    cfg_height = RW'(2);
    @(negedge clk);
    start = 1'b0;
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    chk("t5_busy_later", {31'd0, busy}, 32'd0);
    run_frame(IW, 3, 1, 0);

    // T6: back-to-back, second frame constant 0x7FFF started the cycle after done
    run_frame(5, 5, 0, 0);
    run_frame(3, 3, 2, 0);

    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
